// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - capture FSM state encoding used by uart_rx_fifo
//   - bit positions inside the 16-bit receive status word
//   - bus addresses of the UART data and status registers
// -----------------------------------------------------------------------------
package uart_pkg;

    // Capture handshake with the UART byte receiver
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2
    } cap_state_e;

    // Status register bit positions
    localparam int ST_NONEMPTY = 0;
    localparam int ST_HALF     = 1;
    localparam int ST_FULL     = 2;
    localparam int ST_OVR      = 3;

    // Memory-mapped register addresses decoded by the bus logic
    localparam logic [15:0] UART_DATA_ADDR = 16'h0001;
    localparam logic [15:0] UART_STAT_ADDR = 16'h0002;

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// DEPTH x DATA_W register-array storage for the receive FIFO.
// Synchronous write port, asynchronous (combinational) read port.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module fifo_ram #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // No reset: contents are only visible through the occupancy-gated read
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side buffer between the UART byte receiver and the bus decode of the
// UART data (0x0001) and status (0x0002) registers. Captures each byte flagged
// by rx_new, acknowledges it with a one-cycle rx_ack, and queues it until the
// CPU pops it with bus_rd. Single clock domain (same clock as the UART).
//
// Optional feature macro: UART_RX_THRESH_EN
//   Adds IRQ_THRESH and IDLE_TICKS parameters; irq then fires on a fill
//   threshold, overrun, or an idle timeout while data sits unread.
//   Without it irq = nonempty | overrun (registered).
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   rx_new   in   UART new-byte flag (level, held until acknowledged)
//   rx_data  in   UART received byte, valid while rx_new=1
//   rx_ack   out  one-cycle acknowledge pulse to the UART
//   bus_rd   in   one-cycle pop strobe from the bus decode
//   clr_ovr  in   one-cycle strobe clearing the sticky overrun flag
//   rd_data  out  head-of-FIFO byte, 0 when empty
//   status   out  {12'b0, overrun, full, half, nonempty}
//   irq      out  level interrupt request, registered
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
`ifdef UART_RX_THRESH_EN
    ,
    parameter int          IRQ_THRESH = 4,
    parameter logic [15:0] IDLE_TICKS = 16'd5000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_new,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ack,
    input  logic              bus_rd,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       status,
    output logic              irq
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_HALF = (DEPTH_LOG2 + 1)'(DEPTH / 2);

    cap_state_e            state_q;
    logic                  rx_ack_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovr_q, ovr_d;
    logic                  irq_q, irq_d;
    logic [DATA_W-1:0]     ram_rdata;

    logic nonempty, full, half;
    logic capture, push, pop, drop;

    assign nonempty = (count_q != '0);
    assign full     = (count_q == CNT_FULL);
    assign half     = (count_q >= CNT_HALF);

    // A byte is taken only on the IDLE cycle that sees rx_new, so a slow
    // falling flag can never be pushed twice.
    assign capture = (state_q == IDLE) && rx_new;
    assign pop     = bus_rd && nonempty;
    // When full, a coincident pop frees a slot first, so the push is accepted.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    // ---------------------------------------------------------------------
    // Capture FSM with registered rx_ack (high exactly while in ACK)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rx_ack_q <= 1'b0;
        end else begin
            rx_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_new) begin
                        state_q  <= ACK;
                        rx_ack_q <= 1'b1;
                    end
                end
                ACK:      state_q <= WAIT_CLR;
                WAIT_CLR: if (!rx_new) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Occupancy, overrun and irq next-state
    // ---------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A new overrun beats a coincident clear
    always_comb begin
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

`ifdef UART_RX_THRESH_EN
    logic [15:0] tmr_q, tmr_d;
    logic        tmo_q, tmo_d;

    // Idle timer: reloads on any FIFO activity, counts down while data waits.
    always_comb begin
        tmr_d = tmr_q;
        if (push || pop) begin
            tmr_d = IDLE_TICKS;
        end else if (nonempty && (tmr_q != 16'd0)) begin
            tmr_d = tmr_q - 16'd1;
        end
    end

    always_comb begin
        tmo_d = tmo_q;
        if (pop) begin
            tmo_d = 1'b0;
        end else if (nonempty && !push && (tmr_q == 16'd0)) begin
            tmo_d = 1'b1;
        end
    end

    always_comb begin
        irq_d = (int'(count_q) >= IRQ_THRESH) | ovr_q | tmo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= IDLE_TICKS;
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            tmo_q <= tmo_d;
        end
    end
`else
    always_comb begin
        irq_d = nonempty | ovr_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            irq_q   <= irq_d;
        end
    end

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (rx_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        status              = 16'h0000;
        status[ST_NONEMPTY] = nonempty;
        status[ST_HALF]     = half;
        status[ST_FULL]     = full;
        status[ST_OVR]      = ovr_q;
    end

    assign rd_data = nonempty ? ram_rdata : '0;
    assign rx_ack  = rx_ack_q;
    assign irq     = irq_q;

endmodule
